// File: rtl/hh_spike_detector_if.sv
// hh_spike_detector_if: voltage byte stream in, spike event record out.
// master drives samples and ready; slave (the detector) drives the record.
interface hh_spike_detector_if #(
    parameter int ISI_W = 16
);
    logic [7:0]       v_hi;
    logic [7:0]       v_lo;
    logic             sample_en;
    logic             spike_valid;
    logic             spike_ready;
    logic [ISI_W-1:0] spike_isi;
    logic [15:0]      spike_peak;
    logic [15:0]      spike_count;
    logic             overflow;

    modport master (
        output v_hi, v_lo, sample_en, spike_ready,
        input  spike_valid, spike_isi, spike_peak,
        input  spike_count, overflow
    );

    modport slave (
        input  v_hi, v_lo, sample_en, spike_ready,
        output spike_valid, spike_isi, spike_peak,
        output spike_count, overflow
    );
endinterface

// File: rtl/hh_spike_detector.sv
// hh_spike_detector: hysteresis/refractory spike detector with a one-entry
// valid/ready event buffer. Ports: clk, rst (sync, active-high), bus (slave):
//   v_hi/v_lo/sample_en in, spike_valid/ready handshake, spike_isi,
//   spike_peak, spike_count, sticky overflow.
// Optional: define HH_SPIKE_PEAK_EN to track the peak voltage; otherwise
//   spike_peak is constant 0.
module hh_spike_detector #(
    parameter logic signed [15:0] TH_HI   = 16'sd1024,
    parameter logic signed [15:0] TH_LO   = 16'sd0,
    parameter int                 REFRACT = 4,
    parameter int                 ISI_W   = 16
) (
    input logic                clk,
    input logic                rst,
    hh_spike_detector_if.slave bus
);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_PEAK  = 2'd2;
    localparam logic [1:0] S_REFR  = 2'd3;

    localparam int RW = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);
    localparam logic [RW-1:0] R_LOAD = RW'(REFRACT);
    localparam logic [RW-1:0] R_ONE  = RW'(1);

    logic signed [15:0] v;
    logic               ge_hi;
    logic               le_lo;

    assign v     = $signed({bus.v_hi, bus.v_lo});
    assign ge_hi = (v >= TH_HI);
    assign le_lo = (v <= TH_LO);

    logic [1:0]       state_q, state_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic [ISI_W-1:0] isi_q, isi_d;
    logic [ISI_W-1:0] isi_inc;
    logic [1:0]       exit_st;
    logic             ev;

    // ISI saturates; the captured interval includes the event sample.
    assign isi_inc = (&isi_q) ? isi_q : isi_q + 1'b1;
    assign exit_st = le_lo ? S_ARMED : S_WAIT;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        isi_d   = isi_q;
        ev      = 1'b0;
        if (bus.sample_en) begin
            isi_d = isi_inc;
            unique case (state_q)
                S_WAIT: begin
                    if (le_lo) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (ge_hi) state_d = S_PEAK;
                end
                S_PEAK: begin
                    if (!ge_hi) begin
                        ev    = 1'b1;
                        isi_d = '0;
                        if (REFRACT == 0) begin
                            state_d = exit_st;
                        end else begin
                            state_d = S_REFR;
                            rcnt_d  = R_LOAD;
                        end
                    end
                end
                S_REFR: begin
                    rcnt_d = rcnt_q - 1'b1;
                    // Last refractory sample also decides re-arming.
                    if (rcnt_q == R_ONE) state_d = exit_st;
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    logic valid_q, valid_d;
    logic ovf_q;
    logic [ISI_W-1:0] out_isi_q;
    logic [15:0]      count_q;
    logic             consume;
    logic             load;
    logic             drop;

    assign consume = valid_q && bus.spike_ready;
    assign load    = ev && (!valid_q || bus.spike_ready);
    assign drop    = ev && valid_q && !bus.spike_ready;

    always_comb begin
        valid_d = valid_q;
        if (load)         valid_d = 1'b1;
        else if (consume) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_WAIT;
            rcnt_q    <= '0;
            isi_q     <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            out_isi_q <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            isi_q   <= isi_d;
            valid_q <= valid_d;
            if (load) out_isi_q <= isi_inc;
            // Dropped events still count as detected spikes.
            if (ev)   count_q   <= count_q + 16'd1;
            if (drop) ovf_q     <= 1'b1;
        end
    end

`ifdef HH_SPIKE_PEAK_EN
    logic signed [15:0] peak_q, peak_d;
    logic signed [15:0] out_peak_q;

    always_comb begin
        peak_d = peak_q;
        if (bus.sample_en && ge_hi) begin
            if (state_q == S_ARMED)
                peak_d = v;
            else if ((state_q == S_PEAK) && (v > peak_q))
                peak_d = v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q     <= '0;
            out_peak_q <= '0;
        end else begin
            peak_q <= peak_d;
            // The ending sample is below TH_HI, so peak_q is final here.
            if (load) out_peak_q <= peak_q;
        end
    end

    assign bus.spike_peak = out_peak_q;
`else
    assign bus.spike_peak = '0;
`endif

    assign bus.spike_valid = valid_q;
    assign bus.spike_isi   = out_isi_q;
    assign bus.spike_count = count_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_hh_spike_detector.sv
// tb_hh_spike_detector: directed and random checks of two detectors
// (REFRACT=4 and REFRACT=0) against a history-scanning reference model.
module tb_hh_spike_detector;

    localparam int ISI_W = 16;
    localparam int HIST  = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hh_spike_detector_if #(.ISI_W(ISI_W)) bus0 ();
    hh_spike_detector_if #(.ISI_W(ISI_W)) bus1 ();

    hh_spike_detector #(.REFRACT(4), .ISI_W(ISI_W)) u0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    hh_spike_detector #(.REFRACT(0), .ISI_W(ISI_W)) u1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int checks = 0;
    int errors = 0;

    logic signed [15:0] hist [0:HIST-1];
    int hn = 0;

    bit          exp_valid [2];
    int          exp_isi   [2];
    logic [15:0] exp_peak  [2];
    int          exp_cnt   [2];
    bit          exp_ovf   [2];

    function automatic int rf_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic logic [15:0] pk_exp(input int pk);
`ifdef HH_SPIKE_PEAK_EN
        return 16'(pk);
`else
        return (pk == 12345) ? 16'd0 : 16'd0;
`endif
    endfunction

    // Re-derive all spikes from the full sample history; report whether
    // the newest sample ends one.
    function automatic void scan(input int rf, output bit ev,
                                 output int isi, output int pk);
        int start, prev, a, c, e, mx;
        ev = 1'b0; isi = 0; pk = 0;
        start = 0; prev = -1;
        while (1'b1) begin
            a = start;
            while (a < hn && hist[a] > 0) a++;
            if (a >= hn) return;
            c = a + 1;
            while (c < hn && hist[c] < 1024) c++;
            if (c >= hn) return;
            e = c + 1;
            mx = hist[c];
            while (e < hn && hist[e] >= 1024) begin
                if (hist[e] > mx) mx = hist[e];
                e++;
            end
            if (e >= hn) return;
            if (e == hn - 1) begin
                ev  = 1'b1;
                isi = (e - prev > 65535) ? 65535 : e - prev;
                pk  = mx;
                return;
            end
            prev  = e;
            start = e + rf;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hn = 0;
        for (int k = 0; k < 2; k++) begin
            exp_valid[k] = 1'b0;
            exp_isi[k]   = 0;
            exp_peak[k]  = '0;
            exp_cnt[k]   = 0;
            exp_ovf[k]   = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("u0.valid", 32'(bus0.spike_valid), 32'(exp_valid[0]));
        chk("u0.isi",   32'(bus0.spike_isi),   32'(exp_isi[0]));
        chk("u0.peak",  32'(bus0.spike_peak),  32'(exp_peak[0]));
        chk("u0.count", 32'(bus0.spike_count), 32'(exp_cnt[0]));
        chk("u0.ovf",   32'(bus0.overflow),    32'(exp_ovf[0]));
        chk("u1.valid", 32'(bus1.spike_valid), 32'(exp_valid[1]));
        chk("u1.isi",   32'(bus1.spike_isi),   32'(exp_isi[1]));
        chk("u1.peak",  32'(bus1.spike_peak),  32'(exp_peak[1]));
        chk("u1.count", 32'(bus1.spike_count), 32'(exp_cnt[1]));
        chk("u1.ovf",   32'(bus1.overflow),    32'(exp_ovf[1]));
    endtask

    task automatic step(input bit en, input int v, input bit rdy);
        logic [15:0] vv;
        bit ev;
        int isi, pk;
        vv = 16'(v);
        bus0.sample_en = en;       bus1.sample_en = en;
        bus0.v_hi = vv[15:8];      bus1.v_hi = vv[15:8];
        bus0.v_lo = vv[7:0];       bus1.v_lo = vv[7:0];
        bus0.spike_ready = rdy;    bus1.spike_ready = rdy;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (en && hn < HIST) begin
                hist[hn] = $signed(vv);
                hn++;
            end
            for (int k = 0; k < 2; k++) begin
                ev = 1'b0;
                isi = 0;
                pk = 0;
                if (en) scan(rf_of(k), ev, isi, pk);
                if (ev) begin
                    exp_cnt[k] = (exp_cnt[k] + 1) & 32'hffff;
                    if (!exp_valid[k] || rdy) begin
                        exp_valid[k] = 1'b1;
                        exp_isi[k]   = isi;
                        exp_peak[k]  = pk_exp(pk);
                    end else begin
                        exp_ovf[k] = 1'b1;
                    end
                end else if (exp_valid[k] && rdy) begin
                    exp_valid[k] = 1'b0;
                end
            end
        end
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int vals [10];
        int idx;
        bit en, rdy;
        vals = '{-32768, -500, 0, 1, 500, 1023, 1024, 1500, 3000, 32767};

        do_reset();
        step(1, 0, 1); step(1, 2000, 1); step(1, 3000, 1);
        step(1, 2500, 1); step(1, 100, 1);
        chk("t1.valid", 32'(bus0.spike_valid), 32'd1);
        chk("t1.isi",   32'(bus0.spike_isi),   32'd5);
        chk("t1.peak",  32'(bus0.spike_peak),  32'(pk_exp(3000)));
        chk("t1.count", 32'(bus0.spike_count), 32'd1);
        step(1, 0, 1);
        chk("t1.taken", 32'(bus0.spike_valid), 32'd0);
        step(1, 0, 1);

        do_reset();
        step(1, 2000, 1); step(1, 100, 1); step(1, 0, 1);
        chk("t2.none", 32'(bus0.spike_count), 32'd0);
        step(1, 2000, 1); step(1, 0, 1);
        chk("t2.count", 32'(bus0.spike_count), 32'd1);
        chk("t2.valid", 32'(bus0.spike_valid), 32'd1);

        do_reset();
        step(1, 0, 1); step(1, 2000, 1); step(1, 0, 1);
        step(1, 0, 1); step(1, 2000, 1); step(1, 0, 1);
        chk("t3.r0cnt", 32'(bus1.spike_count), 32'd2);
        chk("t3.r0isi", 32'(bus1.spike_isi),   32'd3);
        step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
        chk("t3.r4cnt", 32'(bus0.spike_count), 32'd1);

        do_reset();
        step(1, 0, 0); step(1, 2000, 0); step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        step(1, 2000, 0); step(1, 0, 0);
        chk("t4.ovf",   32'(bus0.overflow),    32'd1);
        chk("t4.count", 32'(bus0.spike_count), 32'd2);
        chk("t4.held",  32'(bus0.spike_isi),   32'd3);
        chk("t4.valid", 32'(bus0.spike_valid), 32'd1);
        step(0, 0, 1);
        chk("t4.drain", 32'(bus0.spike_valid), 32'd0);

        do_reset();
        step(1, 0, 0); step(1, 2000, 0); step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        step(1, 2000, 0); step(1, 0, 1);
        chk("t5.valid", 32'(bus0.spike_valid), 32'd1);
        chk("t5.ovf",   32'(bus0.overflow),    32'd0);
        chk("t5.isi",   32'(bus0.spike_isi),   32'd7);
        chk("t5.count", 32'(bus0.spike_count), 32'd2);

        do_reset();
        step(1, 0, 0); step(1, 3000, 0); step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        step(1, 2000, 0);
        chk("t6.pre", 32'(bus0.spike_valid), 32'd1);
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        chk("t6.valid", 32'(bus0.spike_valid), 32'd0);
        chk("t6.isi",   32'(bus0.spike_isi),   32'd0);
        chk("t6.peak",  32'(bus0.spike_peak),  32'd0);
        chk("t6.count", 32'(bus0.spike_count), 32'd0);
        chk("t6.ovf",   32'(bus0.overflow),    32'd0);
        step(1, 2000, 1); step(1, 100, 1);
        chk("t6.wait", 32'(bus0.spike_count), 32'd0);
        step(1, 0, 1); step(1, 2000, 1); step(1, 0, 1);
        chk("t6.count2", 32'(bus0.spike_count), 32'd1);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            idx = $urandom_range(0, 9);
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            step(en, vals[idx], rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
